// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (speculative loads vs committed stores) for the single d-cache port.
// Optional perf counters are enabled by defining MEM_PORT_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dc_miss,
  input  logic              flush,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [IDX_W-1:0]  ld_idx,
  output logic              ld_gnt,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              st_full,
  output logic              st_gnt,
  output logic              o_valid,
  output logic              o_mem_action,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic [IDX_W-1:0]  o_idx,
`ifdef MEM_PORT_ARB_PERF_EN
  output logic              o_nop,
  output logic [31:0]       perf_conflict_cnt,
  output logic [31:0]       perf_force_cnt,
  output logic [31:0]       perf_miss_cycles
`else
  output logic              o_nop
`endif
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
  localparam logic       MemRead   = 1'b0;
  localparam logic       MemWrite  = 1'b1;

  typedef enum logic [1:0] {LoadFav, StoreFav, StoreForce} state_e;

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       ld_elig, st_elig;

  // Loads are speculative and die on flush; stores are committed and do not.
  assign ld_elig = ld_req & ~flush & ~dc_miss;
  assign st_elig = st_req & ~dc_miss;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= LoadFav;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (!dc_miss) begin
      unique case (state_q)
        LoadFav: begin
          if (st_gnt) begin
            starve_d = '0;
          end else if (ld_gnt && st_req && starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
          end
          if (st_full) begin
            state_d = StoreForce;
          end else if (starve_d == StarveMax) begin
            state_d = StoreFav;
          end
        end
        StoreFav: begin
          if (st_gnt) begin
            state_d  = LoadFav;
            starve_d = '0;
          end
        end
        StoreForce: begin
          if (st_gnt) begin
            starve_d = '0;
          end
          if (!st_full && (st_gnt || !st_req)) begin
            state_d  = LoadFav;
            starve_d = '0;
          end
        end
        default: begin
          state_d  = LoadFav;
          starve_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    ld_gnt = 1'b0;
    st_gnt = 1'b0;
    if (ld_elig && st_elig) begin
      if (state_q == LoadFav) begin
        ld_gnt = 1'b1;
      end else begin
        st_gnt = 1'b1;
      end
    end else begin
      ld_gnt = ld_elig;
      st_gnt = st_elig;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid      <= 1'b0;
      o_mem_action <= MemRead;
      o_addr       <= '0;
      o_data       <= '0;
      o_idx        <= '0;
      o_nop        <= 1'b1;
    end else if (dc_miss) begin
      // Keep the access so the miss completes; only its result is discarded.
      if (flush && o_mem_action == MemRead) begin
        o_nop <= 1'b1;
      end
    end else if (ld_gnt) begin
      o_valid      <= 1'b1;
      o_mem_action <= MemRead;
      o_addr       <= ld_addr;
      o_data       <= '0;
      o_idx        <= ld_idx;
      o_nop        <= 1'b0;
    end else if (st_gnt) begin
      o_valid      <= 1'b1;
      o_mem_action <= MemWrite;
      o_addr       <= st_addr;
      o_data       <= st_data;
      o_idx        <= '0;
      o_nop        <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_nop   <= 1'b1;
    end
  end

`ifdef MEM_PORT_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_conflict_cnt <= '0;
      perf_force_cnt    <= '0;
      perf_miss_cycles  <= '0;
    end else begin
      if (ld_elig && st_elig) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      if (state_q == StoreForce) perf_force_cnt <= perf_force_cnt + 32'd1;
      if (dc_miss) perf_miss_cycles <= perf_miss_cycles + 32'd1;
    end
  end
`else
`endif

endmodule
